call_return_seq: RTL and testbench

Program-counter sequencer for the uPC core. Each cycle it takes one flow op (NEXT, JUMP, CALL, RET) and drives the return-address stack's push/pop/data pins (count_up, count_down, data_in). On RET it reloads the PC from the stack's asynchronous data_out. It keeps its own depth count to detect overflow/underflow. It sits between the instruction decoder and the stack.

---
 rtl/call_return_seq.sv | 128 ++++++++++++
 tb/tb_call_return_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/call_return_seq.sv
// call_return_seq: PC sequencer for the uPC core. Decodes NEXT/JUMP/CALL/RET
// into return-address stack push/pop pulses and reloads the PC from the
// stack's async top entry one edge after a RET pop.
// All state updates on the falling edge of nclk, in step with the stack.
// Optional: CALLSTACK_GUARD_EN enables full/empty guarding and sticky ovf/unf;
// without it the stack wraps silently and ovf/unf read 0.
module call_return_seq #(
  parameter int             AW       = 8,
  parameter int             DEPTH    = 16,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          nclk,
  input  logic          nreset,
  input  logic          enable,
  input  logic [1:0]    op,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stk_data,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [AW-1:0] stk_wdata,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic [4:0]    depth,
  output logic          ovf,
  output logic          unf
);

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;
  localparam logic [4:0] DMAX    = 5'(DEPTH);

  typedef enum logic {RUN = 1'b0, RET_WAIT = 1'b1} state_e;

  state_e        state, state_nxt;
  logic [AW-1:0] pc_nxt, pc_inc;
  logic [4:0]    depth_nxt, depth_up, depth_dn;
  logic          accept, full, empty;

  assign pc_inc    = pc + 1'b1;
  assign stk_wdata = pc_inc;
  assign accept    = (state == RUN) && enable;

  // Depth steps modulo DEPTH+1; with guarding on the wrap points are never reached.
  assign depth_up = (depth == DMAX)  ? 5'd0 : depth + 5'd1;
  assign depth_dn = (depth == 5'd0)  ? DMAX : depth - 5'd1;

`ifdef CALLSTACK_GUARD_EN
  assign full  = (depth == DMAX);
  assign empty = (depth == 5'd0);
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

  // State register: pc, depth and FSM state on the falling edge.
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      state <= RUN;
      pc    <= RESET_PC;
      depth <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      depth <= depth_nxt;
    end
  end

  // Next-state: RET_WAIT always loads the popped entry; RUN decodes the op.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    depth_nxt = depth;
    if (state == RET_WAIT) begin
      pc_nxt    = stk_data;
      state_nxt = RUN;
    end else if (enable) begin
      case (op)
        OP_NEXT: pc_nxt = pc_inc;
        OP_JUMP: pc_nxt = target;
        OP_CALL: begin
          if (full) pc_nxt = pc_inc;
          else begin
            pc_nxt    = target;
            depth_nxt = depth_up;
          end
        end
        default: begin
          if (empty) pc_nxt = pc_inc;
          else begin
            depth_nxt = depth_dn;
            state_nxt = RET_WAIT;
          end
        end
      endcase
    end
  end

  // Outputs: push/pop are single-cycle decodes, forced low while in reset so
  // the un-reset stack never sees a stray pulse.
  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    busy     = (state == RET_WAIT);
    if (nreset && accept) begin
      stk_push = (op == OP_CALL) && !full;
      stk_pop  = (op == OP_RET)  && !empty;
    end
  end

`ifdef CALLSTACK_GUARD_EN
  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (accept && op == OP_CALL && full)  ovf <= 1'b1;
      if (accept && op == OP_RET  && empty) unf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_call_return_seq.sv
// tb_call_return_seq: directed + random ops against a behavioural model of
// the sequencer (pc rules, depth count, return-address stack as an array).
module tb_call_return_seq;

  localparam int AW = 8;
  localparam int DEPTH = 16;
`ifdef CALLSTACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [1:0] NEXT = 2'b00, JUMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic          nclk = 1'b1;
  logic          nreset = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] stk_data, stk_wdata, pc;
  logic          stk_push, stk_pop, busy, ovf, unf;
  logic [4:0]    depth;

  int checks = 0, passes = 0, fails = 0;

  always #5 nclk = ~nclk;

  call_return_seq #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .nclk(nclk), .nreset(nreset), .enable(enable), .op(op), .target(target),
    .stk_data(stk_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .pc(pc), .busy(busy), .depth(depth),
    .ovf(ovf), .unf(unf)
  );

  // Return-address stack: no reset, 4-bit relative pointer, async top read.
  logic [7:0] mem [16] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                           8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
  logic [3:0] sp = 4'd0;
  always @(negedge nclk) begin
    if (stk_push) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 4'd1;
    end else if (stk_pop) begin
      sp <= sp - 4'd1;
    end
  end
  assign stk_data = mem[sp];

  // Reference model state.
  logic [7:0] m_pc = 8'h00;
  int         m_depth = 0;
  bit         m_busy = 0, m_ovf = 0, m_unf = 0;
  logic [7:0] rs [16];
  int         rsp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("pc", pc, m_pc);
    chk("depth", depth, m_depth);
    chk("busy_q", busy, m_busy);
    chk("ovf", ovf, m_ovf);
    chk("unf", unf, m_unf);
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_depth = 0; m_busy = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One op: drive after the rising edge, check decodes, then state after the fall.
  task automatic step(input bit en, input logic [1:0] o, input logic [7:0] t);
    bit ep, eq;
    logic [7:0] ew;
    @(posedge nclk); #1;
    enable = en; op = o; target = t; #1;
    ep = !m_busy && en && o == CALL && !(GUARD && m_depth == DEPTH);
    eq = !m_busy && en && o == RET  && !(GUARD && m_depth == 0);
    ew = m_pc + 8'd1;
    chk("push", stk_push, ep);
    chk("pop", stk_pop, eq);
    chk("busy", busy, m_busy);
    chk("wdata", stk_wdata, ew);
    @(negedge nclk);
    if (m_busy) begin
      m_pc = rs[rsp];
      m_busy = 0;
    end else if (en) begin
      case (o)
        NEXT: m_pc = m_pc + 8'd1;
        JUMP: m_pc = t;
        CALL: if (GUARD && m_depth == DEPTH) begin
                m_ovf = 1; m_pc = m_pc + 8'd1;
              end else begin
                rs[rsp] = m_pc + 8'd1;
                rsp = (rsp + 1) % 16;
                m_depth = (m_depth + 1) % (DEPTH + 1);
                m_pc = t;
              end
        default: if (GUARD && m_depth == 0) begin
                   m_unf = 1; m_pc = m_pc + 8'd1;
                 end else begin
                   rsp = (rsp + 15) % 16;
                   m_depth = (m_depth + DEPTH) % (DEPTH + 1);
                   m_busy = 1;
                 end
      endcase
    end
    #2;
    chk_state();
  endtask

  // Assert reset between edges with a CALL on the inputs; outputs must drop at once.
  task automatic do_reset();
    @(posedge nclk); #2;
    enable = 1'b1; op = CALL; target = 8'h77;
    nreset = 1'b0; #1;
    model_reset();
    chk("rst_push", stk_push, 1'b0);
    chk("rst_pop", stk_pop, 1'b0);
    chk_state();
    @(negedge nclk); #2;
    chk("rst_hold_pc", pc, 8'h00);
    chk("rst_hold_push", stk_push, 1'b0);
    @(posedge nclk); #1;
    nreset = 1'b1; enable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rs[i] = 8'hA0 + 8'(i);

    // Power-up reset.
    #3;
    chk_state();
    chk("rst0_push", stk_push, 1'b0);
    @(posedge nclk); #1;
    nreset = 1'b1;

    // Sequencing and wrap.
    repeat (3) step(1, NEXT, 8'h00);
    chk("pc_after_3next", pc, 8'h03);
    step(1, JUMP, 8'hFF);
    step(1, NEXT, 8'h00);
    chk("pc_wrap", pc, 8'h00);

    // Single call/return.
    step(1, JUMP, 8'h10);
    step(1, CALL, 8'h40);
    chk("call_pc", pc, 8'h40);
    chk("call_depth", depth, 5'd1);
    step(1, RET, 8'h00);
    step(0, NEXT, 8'h00);
    chk("ret_pc", pc, 8'h11);
    chk("ret_depth", depth, 5'd0);

    // Nest to full, one past, then unwind with ignored CALLs during each wait.
    for (int i = 0; i < 17; i++) step(1, CALL, 8'h80 + 8'(i * 3));
    for (int i = 0; i < 16; i++) begin
      step(1, RET, 8'h00);
      step(1, CALL, 8'h55);
    end

    // Underflow attempt, then keep running.
    step(1, RET, 8'h00);
    step(1, NEXT, 8'h00);
    step(1, NEXT, 8'h00);

    // Mid-run reset.
    do_reset();
    step(1, NEXT, 8'h00);
    chk("post_rst_pc", pc, 8'h01);

    // Busy: ignored op in RET_WAIT, then reset while waiting.
    step(1, CALL, 8'h20);
    step(1, RET, 8'h00);
    step(1, CALL, 8'h33);
    step(1, CALL, 8'h24);
    step(1, RET, 8'h00);
    do_reset();
    step(1, NEXT, 8'h00);
    chk("abort_pc", pc, 8'h01);

    // Random ops.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
